rf_alu_sequencer: RTL and testbench
===================================

Name: rf_alu_sequencer

Overview:
- Initiator-side controller for the team's 8-entry x 8-bit register file: 1 write port, 2 combinational read ports, R0 reads as 0.
- Accepts one 3-operand instruction through a valid/ready handshake.
- Drives the file's read addresses, samples the two read buses, and computes an ALU result.
- Writes the result back through the file's write port and reports it on a result port.
- Sits between the instruction source (testbench or future fetch unit) and the register file.

Parameters:
- DATA_W, 8, datapath width; must equal the register file width.
- ADDR_W, 3, register address width; selects 2**ADDR_W entries.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  sequencer can accept an instruction.
- in_op  input  3  ALU opcode.
- in_rd  input  ADDR_W  destination register.
- in_rs  input  ADDR_W  source register X.
- in_rt  input  ADDR_W  source register Y.
- WEN  output  1  register file write enable.
- RW  output  ADDR_W  register file write address.
- busW  output  DATA_W  register file write data.
- RX  output  ADDR_W  register file read address X.
- RY  output  ADDR_W  register file read address Y.
- busX  input  DATA_W  read data X from the register file.
- busY  input  DATA_W  read data Y from the register file.
- out_valid  output  1  one-cycle pulse; result written.
- out_data  output  DATA_W  result value.
- out_carry  output  1  carry/borrow of ADD/SUB; 0 for other ops.

Behaviour:
- Reset (Rst_n=0 at a rising Clk edge):
  - State goes to IDLE.
  - in_ready=1, WEN=0, out_valid=0, out_data=0, out_carry=0.
  - RW, RX, RY, busW all 0.
  - Reset mid-instruction aborts it. No write is issued; WEN is low from the next cycle.
- FSM states: IDLE, READ, EXEC, WB. All outputs are registered.
  - IDLE: in_ready=1. When in_valid=1, latch op/rd/rs/rt and go to READ. When in_valid=0, stay in IDLE.
  - READ: RX=rs and RY=rt are driven (registered on entry). The read path is combinational, so busX and busY are captured into operand registers at the end of this cycle. Go to EXEC.
  - EXEC: compute result and carry from the captured operands; register them. Go to WB.
  - WB: WEN=1, RW=rd, busW=result. out_valid=1, out_data=result, out_carry=carry. Exactly one cycle, then back to IDLE.
- in_ready=0 in READ, EXEC and WB. in_valid is ignored there.
- Latency: handshake in cycle 0, WEN/out_valid in cycle 3. Maximum throughput is 1 instruction per 4 cycles.
- Data hazards cannot occur: the write completes before the next instruction is accepted.
- Opcodes (all arithmetic modulo 2**DATA_W, unsigned):
  - 000 ADD: X+Y; carry = bit DATA_W of the sum.
  - 001 SUB: X-Y; carry = borrow (1 when X<Y).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: X << Y[2:0].
  - 110 SRL: X >> Y[2:0], logical.
  - 111 SLTU: result 1 if X<Y, else 0.
- rd=0: the write is still issued with WEN=1; the register file keeps reading R0 as 0. out_data shows the computed value.
- rs=rt is legal: both buses carry the same value.
- WEN is never high outside WB.

Optional Feature:
- Macro RF_SEQ_SATURATE_EN.
- When defined:
  - ADD clamps to all-ones on carry.
  - SUB clamps to 0 on borrow.
  - out_carry still reports the raw carry/borrow.
- When undefined: ADD and SUB wrap modulo 2**DATA_W. No saturation logic is synthesized.

Decomposition:
- Package rf_seq_pkg holds:
  - opcode constants OP_ADD..OP_SLTU;
  - FSM state encoding (IDLE=0, READ=1, EXEC=2, WB=3);
  - default DATA_W and ADDR_W.
- One sub-module, rf_seq_alu: purely combinational; inputs op/X/Y, outputs result/carry; contains the saturation option.
- FSM, operand registers and the register-file port drive stay in rf_alu_sequencer.

Test Plan:
- Reset then idle: Rst_n low 2 cycles, then high -> in_ready=1; WEN, out_valid, RW, RX, RY, busW all 0.
- Preload R1=0xF0, R2=0x20 via ADD/OR from R0; then ADD rd=3,rs=1,rt=2:
  - WEN=1, RW=3, busW=0x10 exactly 3 cycles after the handshake; out_carry=1.
  - With RF_SEQ_SATURATE_EN: busW=0xFF.
- SUB rd=4,rs=2,rt=1 (0x20-0xF0) -> busW=0x30, out_carry=1. SLTU same operands -> 1. SLL R1 by R2[2:0]=0 -> 0xF0.
- Write to R0: ADD rd=0 issues WEN=1, RW=0; a following OR rd=5,rs=0,rt=0 -> busW=0x00.
- Backpressure: hold in_valid=1 with changing instructions -> each accepted only when in_ready=1; exactly one WEN pulse per accepted instruction, every 4 cycles.
- Rst_n low during EXEC -> no WEN pulse and no out_valid; destination register unchanged; in_ready=1 the cycle after reset.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file ALU sequencer: default widths,
// ALU opcodes and the FSM state encoding.
package rf_seq_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SLL  = 3'b101;
   localparam logic [2:0] OP_SRL  = 3'b110;
   localparam logic [2:0] OP_SLTU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

endpackage

// File: rtl/rf_alu_sequencer_if.sv
// Bundle of the instruction handshake, register-file port and result port.
// master = sequencer side, slave = instruction source / register file side.
interface rf_alu_sequencer_if
   import rf_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [ADDR_W-1:0] in_rd;
   logic [ADDR_W-1:0] in_rs;
   logic [ADDR_W-1:0] in_rt;

   logic              WEN;
   logic [ADDR_W-1:0] RW;
   logic [DATA_W-1:0] busW;
   logic [ADDR_W-1:0] RX;
   logic [ADDR_W-1:0] RY;
   logic [DATA_W-1:0] busX;
   logic [DATA_W-1:0] busY;

   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_carry;

   modport master (
      input  in_valid, in_op, in_rd, in_rs, in_rt, busX, busY,
      output in_ready, WEN, RW, busW, RX, RY, out_valid, out_data, out_carry
   );

   modport slave (
      output in_valid, in_op, in_rd, in_rs, in_rt, busX, busY,
      input  in_ready, WEN, RW, busW, RX, RY, out_valid, out_data, out_carry
   );

endinterface

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer. Defining RF_SEQ_SATURATE_EN makes ADD
// clamp to all-ones on carry and SUB clamp to zero on borrow.
module rf_seq_alu
   import rf_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // The extra top bit of the difference is the borrow, reused by SLTU.
   assign sum  = {1'b0, x} + {1'b0, y};
   assign diff = {1'b0, x} - {1'b0, y};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            carry = sum[DATA_W];
`ifdef RF_SEQ_SATURATE_EN
            result = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
            result = sum[DATA_W-1:0];
`endif
         end
         OP_SUB: begin
            carry = diff[DATA_W];
`ifdef RF_SEQ_SATURATE_EN
            result = diff[DATA_W] ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
`else
            result = diff[DATA_W-1:0];
`endif
         end
         OP_AND:  result = x & y;
         OP_OR:   result = x | y;
         OP_XOR:  result = x ^ y;
         OP_SLL:  result = x << y[2:0];
         OP_SRL:  result = x >> y[2:0];
         OP_SLTU: result = {{(DATA_W-1){1'b0}}, diff[DATA_W]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Register-file ALU sequencer: accepts one 3-operand instruction, reads the
// operands, computes via rf_seq_alu and writes back. Option: RF_SEQ_SATURATE_EN.
module rf_alu_sequencer
   import rf_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input logic                Clk,
   input logic                Rst_n,
   rf_alu_sequencer_if.master bus
);

   state_t state, next_state;

   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] opx_q, opx_d;
   logic [DATA_W-1:0] opy_q, opy_d;

   logic              in_ready_q, in_ready_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] rw_q, rw_d;
   logic [DATA_W-1:0] busw_q, busw_d;
   logic [ADDR_W-1:0] rx_q, rx_d;
   logic [ADDR_W-1:0] ry_q, ry_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_carry_q, out_carry_d;

   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;

   rf_seq_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op     (op_q),
      .x      (opx_q),
      .y      (opy_q),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // Every output is a register; reset also aborts any instruction in flight.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state       <= IDLE;
         op_q        <= '0;
         rd_q        <= '0;
         opx_q       <= '0;
         opy_q       <= '0;
         in_ready_q  <= 1'b1;
         wen_q       <= 1'b0;
         rw_q        <= '0;
         busw_q      <= '0;
         rx_q        <= '0;
         ry_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_carry_q <= 1'b0;
      end else begin
         state       <= next_state;
         op_q        <= op_d;
         rd_q        <= rd_d;
         opx_q       <= opx_d;
         opy_q       <= opy_d;
         in_ready_q  <= in_ready_d;
         wen_q       <= wen_d;
         rw_q        <= rw_d;
         busw_q      <= busw_d;
         rx_q        <= rx_d;
         ry_q        <= ry_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_carry_q <= out_carry_d;
      end
   end

   // Next-state logic computes the value each output register takes on entry
   // to the next state, so WEN/out_valid are high exactly while in WB.
   always_comb begin
      next_state  = state;
      op_d        = op_q;
      rd_d        = rd_q;
      opx_d       = opx_q;
      opy_d       = opy_q;
      in_ready_d  = 1'b0;
      wen_d       = 1'b0;
      rw_d        = rw_q;
      busw_d      = busw_q;
      rx_d        = rx_q;
      ry_d        = ry_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_carry_d = out_carry_q;

      case (state)
         IDLE: begin
            in_ready_d = 1'b1;
            if (bus.in_valid) begin
               op_d       = bus.in_op;
               rd_d       = bus.in_rd;
               rx_d       = bus.in_rs;
               ry_d       = bus.in_rt;
               in_ready_d = 1'b0;
               next_state = READ;
            end
         end
         READ: begin
            opx_d      = bus.busX;
            opy_d      = bus.busY;
            next_state = EXEC;
         end
         EXEC: begin
            wen_d       = 1'b1;
            rw_d        = rd_q;
            busw_d      = alu_result;
            out_valid_d = 1'b1;
            out_data_d  = alu_result;
            out_carry_d = alu_carry;
            next_state  = WB;
         end
         WB: begin
            in_ready_d = 1'b1;
            next_state = IDLE;
         end
         default: begin
            in_ready_d = 1'b1;
            next_state = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.WEN       = wen_q;
   assign bus.RW        = rw_q;
   assign bus.busW      = busw_q;
   assign bus.RX        = rx_q;
   assign bus.RY        = ry_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_carry = out_carry_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench for rf_alu_sequencer with a behavioural 8x8 register file.
// Expected values follow RF_SEQ_SATURATE_EN when the macro is defined.
module tb_rf_alu_sequencer
   import rf_seq_pkg::*;
;

   logic Clk;
   logic Rst_n;
   logic rf_init;
   int   checks;
   int   errors;

   rf_alu_sequencer_if #(.DATA_W(8), .ADDR_W(3)) bus ();

   rf_alu_sequencer #(
      .DATA_W (8),
      .ADDR_W (3)
   ) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

`ifdef RF_SEQ_SATURATE_EN
   localparam logic [7:0] EXP_ADD = 8'hFF;
   localparam logic [7:0] EXP_SUB = 8'h00;
`else
   localparam logic [7:0] EXP_ADD = 8'h10;
   localparam logic [7:0] EXP_SUB = 8'h30;
`endif

   // {op, rd, rs, rt, result, carry}; R1=0xF0 and R2=0x20 are preloaded
   localparam logic [20:0] ALU_VEC [11] = '{
      {OP_ADD,  3'd3, 3'd1, 3'd2, EXP_ADD, 1'b1},
      {OP_SUB,  3'd4, 3'd2, 3'd1, EXP_SUB, 1'b1},
      {OP_SLTU, 3'd6, 3'd2, 3'd1, 8'h01,   1'b0},
      {OP_SLL,  3'd7, 3'd1, 3'd2, 8'hF0,   1'b0},
      {OP_SRL,  3'd7, 3'd1, 3'd6, 8'h78,   1'b0},
      {OP_SLL,  3'd5, 3'd1, 3'd6, 8'hE0,   1'b0},
      {OP_AND,  3'd5, 3'd1, 3'd2, 8'h20,   1'b0},
      {OP_XOR,  3'd5, 3'd1, 3'd2, 8'hD0,   1'b0},
      {OP_SUB,  3'd5, 3'd1, 3'd2, 8'hD0,   1'b0},
      {OP_SLTU, 3'd5, 3'd1, 3'd2, 8'h00,   1'b0},
      {OP_ADD,  3'd5, 3'd2, 3'd2, 8'h40,   1'b0}
   };

   // {op, rd, rs, rt, result}
   localparam logic [19:0] B2B_VEC [6] = '{
      {OP_AND,  3'd5, 3'd1, 3'd2, 8'h20},
      {OP_OR,   3'd5, 3'd1, 3'd2, 8'hF0},
      {OP_XOR,  3'd5, 3'd1, 3'd2, 8'hD0},
      {OP_SUB,  3'd5, 3'd1, 3'd2, 8'hD0},
      {OP_SLTU, 3'd5, 3'd2, 3'd1, 8'h01},
      {OP_SRL,  3'd5, 3'd1, 3'd2, 8'hF0}
   };

   logic [7:0] rf [8];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (rf_init) begin
         for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
         rf[1] <= 8'hF0;
         rf[2] <= 8'h20;
      end else if (bus.WEN && bus.RW != 3'd0) begin
         rf[bus.RW] <= bus.busW;
      end
   end

   assign bus.busX = (bus.RX == 3'd0) ? 8'h00 : rf[bus.RX];
   assign bus.busY = (bus.RY == 3'd0) ? 8'h00 : rf[bus.RY];

   // Issues one instruction and samples the port during the three following cycles.
   task automatic run_instr(input logic [2:0] op, input logic [2:0] rd,
                            input logic [2:0] rs, input logic [2:0] rt,
                            output int early, output logic wen, output logic [2:0] rw,
                            output logic [7:0] busw, output logic ov,
                            output logic [7:0] od, output logic oc,
                            output logic timed_out);
      int n;
      early     = 0;
      timed_out = 1'b0;
      n         = 0;
      @(negedge Clk);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_rd    = rd;
      bus.in_rs    = rs;
      bus.in_rt    = rt;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      if (bus.in_ready !== 1'b1) timed_out = 1'b1;
      @(negedge Clk);
      bus.in_valid = 1'b0;
      early += int'(bus.WEN | bus.out_valid);
      @(negedge Clk);
      early += int'(bus.WEN | bus.out_valid);
      @(negedge Clk);
      wen  = bus.WEN;
      rw   = bus.RW;
      busw = bus.busW;
      ov   = bus.out_valid;
      od   = bus.out_data;
      oc   = bus.out_carry;
      @(negedge Clk);
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      rf_init = 1'b1;
      @(negedge Clk);
      rf_init = 1'b0;
      @(negedge Clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.WEN !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_held: in_ready=%b WEN=%b, required 1/0", bus.in_ready, bus.WEN);
      end
      Rst_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b, required 1", bus.in_ready);
      end
      checks++;
      if (bus.WEN !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_pulses: WEN=%b out_valid=%b, required 0/0", bus.WEN, bus.out_valid);
      end
      checks++;
      if ({bus.RW, bus.RX, bus.RY} !== 9'd0 || bus.busW !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_addr: RW=%0d RX=%0d RY=%0d busW=%h, required all 0",
                  bus.RW, bus.RX, bus.RY, bus.busW);
      end
      checks++;
      if (bus.out_data !== 8'h00 || bus.out_carry !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_result: out_data=%h out_carry=%b, required 00/0",
                  bus.out_data, bus.out_carry);
      end
   endtask

   task automatic test_alu();
      logic [20:0] v;
      int          early;
      logic        wen, ov, oc, to;
      logic [2:0]  rw;
      logic [7:0]  busw, od;
      for (int i = 0; i < 11; i++) begin
         v = ALU_VEC[i];
         run_instr(v[20:18], v[17:15], v[14:12], v[11:9], early, wen, rw, busw, ov, od, oc, to);
         checks++;
         if (to !== 1'b0 || early != 0) begin
            errors++;
            $display("[TB] FAIL alu%0d_timing: timeout=%b early_pulses=%0d, required 0/0", i, to, early);
         end
         checks++;
         if (wen !== 1'b1 || ov !== 1'b1 || rw !== v[17:15]) begin
            errors++;
            $display("[TB] FAIL alu%0d_wb: WEN=%b out_valid=%b RW=%0d, required 1/1/%0d",
                     i, wen, ov, rw, v[17:15]);
         end
         checks++;
         if (busw !== v[8:1] || od !== v[8:1]) begin
            errors++;
            $display("[TB] FAIL alu%0d_data: busW=%h out_data=%h, required %h", i, busw, od, v[8:1]);
         end
         checks++;
         if (oc !== v[0]) begin
            errors++;
            $display("[TB] FAIL alu%0d_carry: got %b, required %b", i, oc, v[0]);
         end
         checks++;
         if (rf[v[17:15]] !== v[8:1]) begin
            errors++;
            $display("[TB] FAIL alu%0d_rf: R%0d=%h, required %h", i, v[17:15], rf[v[17:15]], v[8:1]);
         end
      end
   endtask

   task automatic test_r0_write();
      int         early;
      logic       wen, ov, oc, to;
      logic [2:0] rw;
      logic [7:0] busw, od;
      run_instr(OP_ADD, 3'd0, 3'd1, 3'd2, early, wen, rw, busw, ov, od, oc, to);
      checks++;
      if (to !== 1'b0 || wen !== 1'b1 || rw !== 3'd0) begin
         errors++;
         $display("[TB] FAIL r0_write: timeout=%b WEN=%b RW=%0d, required 0/1/0", to, wen, rw);
      end
      checks++;
      if (od !== EXP_ADD) begin
         errors++;
         $display("[TB] FAIL r0_out_data: got %h, required %h", od, EXP_ADD);
      end
      run_instr(OP_OR, 3'd5, 3'd0, 3'd0, early, wen, rw, busw, ov, od, oc, to);
      checks++;
      if (wen !== 1'b1 || busw !== 8'h00 || rf[5] !== 8'h00) begin
         errors++;
         $display("[TB] FAIL r0_read: WEN=%b busW=%h R5=%h, required 1/00/00", wen, busw, rf[5]);
      end
   endtask

   task automatic test_back_to_back();
      int         acc_cycle [$];
      int         acc_idx [$];
      int         wen_cycle [$];
      logic [7:0] wen_data [$];
      logic [19:0] v;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clk);
         if (bus.WEN === 1'b1) begin
            wen_cycle.push_back(c);
            wen_data.push_back(bus.busW);
         end
         if (c < 16) begin
            v = B2B_VEC[c % 6];
            bus.in_valid = 1'b1;
            bus.in_op    = v[19:17];
            bus.in_rd    = v[16:14];
            bus.in_rs    = v[13:11];
            bus.in_rt    = v[10:8];
            if (bus.in_ready === 1'b1) begin
               acc_cycle.push_back(c);
               acc_idx.push_back(c % 6);
            end
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      checks++;
      if (acc_cycle.size() != 4 || wen_cycle.size() != 4) begin
         errors++;
         $display("[TB] FAIL b2b_counts: accepted=%0d writes=%0d, required 4/4",
                  acc_cycle.size(), wen_cycle.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            v = B2B_VEC[acc_idx[k]];
            checks++;
            if (acc_cycle[k] != 4 * k || wen_cycle[k] != 4 * k + 3) begin
               errors++;
               $display("[TB] FAIL b2b_timing%0d: accept=%0d write=%0d, required %0d/%0d",
                        k, acc_cycle[k], wen_cycle[k], 4 * k, 4 * k + 3);
            end
            checks++;
            if (wen_data[k] !== v[7:0]) begin
               errors++;
               $display("[TB] FAIL b2b_data%0d: busW=%h, required %h", k, wen_data[k], v[7:0]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      @(negedge Clk);
      bus.in_valid = 1'b1;
      bus.in_op    = OP_ADD;
      bus.in_rd    = 3'd3;
      bus.in_rs    = 3'd2;
      bus.in_rt    = 3'd2;
      @(negedge Clk);
      bus.in_valid = 1'b0;
      pulses += int'(bus.WEN | bus.out_valid);
      @(negedge Clk);
      pulses += int'(bus.WEN | bus.out_valid);
      Rst_n = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.WEN !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_state: in_ready=%b WEN=%b out_valid=%b, required 1/0/0",
                  bus.in_ready, bus.WEN, bus.out_valid);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         pulses += int'(bus.WEN | bus.out_valid);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("[TB] FAIL midreset_pulses: got %0d, required 0", pulses);
      end
      checks++;
      if (rf[3] !== EXP_ADD) begin
         errors++;
         $display("[TB] FAIL midreset_rf: R3=%h, required %h", rf[3], EXP_ADD);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      Rst_n        = 1'b0;
      rf_init      = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_op    = 3'd0;
      bus.in_rd    = 3'd0;
      bus.in_rs    = 3'd0;
      bus.in_rt    = 3'd0;
      test_reset();
      test_alu();
      test_r0_write();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
